// File: rtl/normalizer.sv
// Iterative normalizer: shifts a 32-bit operand one bit per cycle until its
// MSB (mode 0) or LSB (mode 1) is set, reporting the shift count. A zero
// operand short-circuits straight to completion with a count of 32.
module normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic        mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic [5:0]  shamt,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] work_q,  work_d;
  logic [4:0]  cnt_q,   cnt_d;    // a nonzero operand never needs more than 31 shifts
  logic        mode_q,  mode_d;
  logic [31:0] out_q,   out_d;
  logic [5:0]  shamt_q, shamt_d;
  logic        zero_q,  zero_d;
  logic        exit_bit;

  // Next-state logic: one exit test or one shift per cycle; results load only on completion.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    out_d    = out_q;
    shamt_d  = shamt_q;
    zero_d   = zero_q;
    exit_bit = mode_q ? work_q[0] : work_q[31];
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d = A;
          cnt_d  = 5'd0;
          mode_d = mode;
          if (A == 32'd0) begin
            // Nothing to normalize: report 32 and skip the shift loop.
            state_d = DONE;
            out_d   = 32'd0;
            shamt_d = 6'd32;
            zero_d  = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (exit_bit) begin
          state_d = DONE;
          out_d   = work_q;
          shamt_d = {1'b0, cnt_q};
          zero_d  = 1'b0;
        end else begin
          work_d = mode_q ? (work_q >> 1) : (work_q << 1);
          cnt_d  = cnt_q + 5'd1;
        end
      end
      DONE: begin
        // start is deliberately ignored here; the next request is taken from IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= 32'd0;
      cnt_q   <= 5'd0;
      mode_q  <= 1'b0;
      out_q   <= 32'd0;
      shamt_q <= 6'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      shamt_q <= shamt_d;
      zero_q  <= zero_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign out   = out_q;
  assign shamt = shamt_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_normalizer.sv
// Randomized self-checking bench for the normalizer, with directed corner cases.
module tb_normalizer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic        mode;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic [5:0]  shamt;
  logic        zero;

  int total;
  int bad;

  normalizer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .shamt (shamt),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: count zeros from the relevant end by scanning bit positions.
  function automatic int ref_count(input logic [31:0] a, input logic m);
    int n;
    n = 0;
    if (a == 32'd0) return 32;
    if (m == 1'b0) begin
      for (int i = 31; i >= 0; i--) begin
        if (a[i]) break;
        n++;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (a[i]) break;
        n++;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] ref_out(input logic [31:0] a, input logic m);
    int k;
    k = ref_count(a, m);
    if (a == 32'd0) return 32'd0;
    return m ? (a >> k) : (a << k);
  endfunction

  // Launch one operation and check latency, busy, stable outputs and results.
  // With noise set, start is held high with a different operand while busy.
  task automatic run_op(input logic [31:0] a, input logic m, input bit noise);
    int          k;
    int          n;
    int          exp_lat;
    logic [31:0] prev_out;
    logic [5:0]  prev_sh;
    logic        prev_z;
    k        = ref_count(a, m);
    exp_lat  = (a == 32'd0) ? 0 : k + 1;
    prev_out = out;
    prev_sh  = shamt;
    prev_z   = zero;
    @(negedge clk);
    start = 1'b1;
    A     = a;
    mode  = m;
    @(posedge clk);
    #1;
    if (noise) begin
      A    = 32'hFFFF_FFFF;
      mode = ~m;
    end else begin
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 40) begin
      chk("busy_in_shift", busy, 1'b1);
      chk("out_held", {zero, shamt, out}, {prev_z, prev_sh, prev_out});
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_seen", done, 1'b1);
    chk("latency", n, exp_lat);
    chk("busy_in_done", busy, 1'b1);
    chk("out", out, ref_out(a, m));
    chk("shamt", shamt, k);
    chk("zero", zero, (a == 32'd0));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_pulse_end", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    // Results stay put in IDLE and no spurious second completion appears.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no_extra_done", done, 1'b0);
      chk("hold_idle", {zero, shamt, out}, {(a == 32'd0), 6'(k), ref_out(a, m)});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b1;
    A     = 32'h1234_5678;
    mode  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out", out, 32'd0);
    chk("rst_shamt", shamt, 6'd0);
    chk("rst_zero", zero, 1'b0);
    rst   = 1'b0;
    start = 1'b0;

    // Directed corner cases.
    run_op(32'h8000_0000, 1'b0, 1'b0);
    run_op(32'h0000_0001, 1'b0, 1'b0);
    run_op(32'h0000_0000, 1'b0, 1'b0);
    run_op(32'h0000_0000, 1'b1, 1'b0);
    run_op(32'h0000_0F00, 1'b1, 1'b0);
    run_op(32'h00F0_0000, 1'b0, 1'b0);
    run_op(32'h8000_0000, 1'b1, 1'b0);
    run_op(32'h0000_0001, 1'b0, 1'b1);

    // Reset during the fifth SHIFT cycle aborts the operation.
    @(negedge clk);
    start = 1'b1;
    A     = 32'h0000_0001;
    mode  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_abort_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_out", out, 32'd0);
    chk("abort_shamt", shamt, 6'd0);
    chk("abort_zero", zero, 1'b0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (done) seen++;
      end
      chk("abort_no_done", seen, 0);
    end
    run_op(32'h0001_0000, 1'b0, 1'b0);

    // Randomized operands with varied zero runs at both ends.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic        m;
      int          sel;
      a   = $urandom;
      m   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 32'd0;
      else if (sel < 5)  a = a >> $urandom_range(0, 31);
      else if (sel < 9)  a = a << $urandom_range(0, 31);
      if (sel != 0 && a == 32'd0) a = 32'h0000_0100;
      run_op(a, m, ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
